// File: rtl/reg_file_seq_pkg.sv
// -----------------------------------------------------------------------------
// reg_file_seq_pkg
// Shared definitions for the register-file instruction sequencer:
//   - default data / address widths
//   - sequencer state encoding
//   - opcode constants (NOP) and instruction field bit positions
//   - small decode helper used by the instruction decoder
// -----------------------------------------------------------------------------
package reg_file_seq_pkg;

  // Default widths of the datapath and register address.
  localparam int DATA_W_DEF = 9;
  localparam int ADDR_W_DEF = 2;

  // Instruction word layout: [8:6] opcode, [5:4] dest, [3:2] src0, [1:0] src1.
  localparam int INSTR_W  = 9;
  localparam int OPC_W    = 3;
  localparam int FLD_W    = 2;
  localparam int OPC_LSB  = 6;
  localparam int DEST_LSB = 4;
  localparam int SRC0_LSB = 2;
  localparam int SRC1_LSB = 0;

  // Opcode that walks the whole sequence but never writes the register file.
  localparam logic [OPC_W-1:0] OP_NOP = 3'b111;

  // Sequencer states; one instruction visits every state exactly once.
  typedef enum logic [2:0] {
    ST_IDLE = 3'd0,
    ST_READ = 3'd1,
    ST_OPND = 3'd2,
    ST_EXEC = 3'd3,
    ST_WB   = 3'd4
  } state_e;

  // True when the opcode must suppress the register-file write.
  function automatic logic is_nop(input logic [OPC_W-1:0] op);
    return (op == OP_NOP);
  endfunction

endpackage

// File: rtl/reg_file_seq_instr_decode.sv
// -----------------------------------------------------------------------------
// instr_decode
// Purely combinational field extraction for one sequencer instruction word.
// Ports:
//   instr_i   in  INSTR_W  instruction word
//   opcode_o  out OPC_W    opcode field
//   dest_o    out FLD_W    destination register field
//   src0_o    out FLD_W    first source register field
//   src1_o    out FLD_W    second source register field
//   is_nop_o  out 1        opcode is NOP (write-back suppressed)
// -----------------------------------------------------------------------------
module instr_decode
  import reg_file_seq_pkg::*;
(
  input  logic [INSTR_W-1:0] instr_i,
  output logic [OPC_W-1:0]   opcode_o,
  output logic [FLD_W-1:0]   dest_o,
  output logic [FLD_W-1:0]   src0_o,
  output logic [FLD_W-1:0]   src1_o,
  output logic               is_nop_o
);

  // Slice the instruction fields out of the word.
  always_comb begin
    opcode_o = instr_i[OPC_LSB  +: OPC_W];
    dest_o   = instr_i[DEST_LSB +: FLD_W];
    src0_o   = instr_i[SRC0_LSB +: FLD_W];
    src1_o   = instr_i[SRC1_LSB +: FLD_W];
    is_nop_o = is_nop(instr_i[OPC_LSB +: OPC_W]);
  end

endmodule

// File: rtl/reg_file_seq.sv
// -----------------------------------------------------------------------------
// reg_file_seq
// Fixed-latency instruction sequencer driving an external register file and
// an external combinational ALU. One instruction is processed at a time:
//   IDLE -> READ -> OPND -> EXEC -> WB -> IDLE
// Handshake on edge N gives write-back/done in cycle N+4 and a new accept
// opportunity in cycle N+5.
// Ports:
//   clk           in   clock, rising-edge
//   rst           in   asynchronous reset, active-low
//   instr_valid   in   instruction offered
//   instr_ready   out  sequencer idle and able to accept
//   instr         in   [8:6] opcode, [5:4] dest, [3:2] src0, [1:0] src1
//   rf_rd_en      out  register-file read strobe (READ only)
//   rf_rd0_addr   out  read address 0 (src0)
//   rf_rd1_addr   out  read address 1 (src1)
//   rf_rd0_data   in   read data 0, valid the cycle after rf_rd_en
//   rf_rd1_data   in   read data 1, valid the cycle after rf_rd_en
//   rf_wr_en      out  register-file write strobe (WB, non-NOP)
//   rf_wr_addr    out  write address (dest)
//   rf_wr_data    out  write data (captured ALU result)
//   alu_a, alu_b  out  registered ALU operands
//   alu_op        out  opcode presented to the ALU
//   alu_result    in   combinational ALU result
//   done          out  one-cycle pulse when an instruction retires
//   busy          out  high whenever the sequencer is not idle
// -----------------------------------------------------------------------------
module reg_file_seq
  import reg_file_seq_pkg::*;
#(
  parameter int DATA_W = DATA_W_DEF,
  parameter int ADDR_W = ADDR_W_DEF
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic                     instr_valid,
  output logic                     instr_ready,
  input  logic [INSTR_W-1:0]       instr,
  output logic                     rf_rd_en,
  output logic [ADDR_W-1:0]        rf_rd0_addr,
  output logic [ADDR_W-1:0]        rf_rd1_addr,
  input  logic signed [DATA_W-1:0] rf_rd0_data,
  input  logic signed [DATA_W-1:0] rf_rd1_data,
  output logic                     rf_wr_en,
  output logic [ADDR_W-1:0]        rf_wr_addr,
  output logic signed [DATA_W-1:0] rf_wr_data,
  output logic signed [DATA_W-1:0] alu_a,
  output logic signed [DATA_W-1:0] alu_b,
  output logic [OPC_W-1:0]         alu_op,
  input  logic signed [DATA_W-1:0] alu_result,
  output logic                     done,
  output logic                     busy
);

  state_e                   state_q, state_d;
  logic [INSTR_W-1:0]       instr_q, instr_d;
  logic signed [DATA_W-1:0] alu_a_q, alu_a_d;
  logic signed [DATA_W-1:0] alu_b_q, alu_b_d;
  logic signed [DATA_W-1:0] result_q, result_d;

  // Control strobes are registered; their next values are decoded from the
  // next state so they line up exactly with the state they belong to.
  logic ready_q, ready_d;
  logic busy_q, busy_d;
  logic rd_en_q, rd_en_d;
  logic wr_en_q, wr_en_d;
  logic done_q, done_d;

  logic [OPC_W-1:0] opcode_s;
  logic [FLD_W-1:0] dest_s;
  logic [FLD_W-1:0] src0_s;
  logic [FLD_W-1:0] src1_s;
  logic             nop_s;

  // Fields always come from the latched word, so addresses and opcode stay
  // stable for the whole READ..WB window regardless of the instr input.
  instr_decode u_instr_decode (
    .instr_i  (instr_q),
    .opcode_o (opcode_s),
    .dest_o   (dest_s),
    .src0_o   (src0_s),
    .src1_o   (src1_s),
    .is_nop_o (nop_s)
  );

  // State, latched instruction, datapath and control-strobe registers.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q  <= ST_IDLE;
      instr_q  <= {INSTR_W{1'b0}};
      alu_a_q  <= {DATA_W{1'b0}};
      alu_b_q  <= {DATA_W{1'b0}};
      result_q <= {DATA_W{1'b0}};
      ready_q  <= 1'b1;
      busy_q   <= 1'b0;
      rd_en_q  <= 1'b0;
      wr_en_q  <= 1'b0;
      done_q   <= 1'b0;
    end else begin
      state_q  <= state_d;
      instr_q  <= instr_d;
      alu_a_q  <= alu_a_d;
      alu_b_q  <= alu_b_d;
      result_q <= result_d;
      ready_q  <= ready_d;
      busy_q   <= busy_d;
      rd_en_q  <= rd_en_d;
      wr_en_q  <= wr_en_d;
      done_q   <= done_d;
    end
  end

  // Next-state and datapath capture logic.
  always_comb begin
    state_d  = state_q;
    instr_d  = instr_q;
    alu_a_d  = alu_a_q;
    alu_b_d  = alu_b_q;
    result_d = result_q;
    case (state_q)
      ST_IDLE: begin
        if (instr_valid && ready_q) begin
          instr_d = instr;
          state_d = ST_READ;
        end else begin
          state_d = ST_IDLE;
        end
      end
      ST_READ: begin
        state_d = ST_OPND;
      end
      ST_OPND: begin
        // Register file data launched by the READ strobe is valid now.
        alu_a_d = rf_rd0_data;
        alu_b_d = rf_rd1_data;
        state_d = ST_EXEC;
      end
      ST_EXEC: begin
        result_d = alu_result;
        state_d  = ST_WB;
      end
      ST_WB: begin
        state_d = ST_IDLE;
      end
      default: begin
        state_d = ST_IDLE;
      end
    endcase
  end

  // Strobe decode from the next state. Entry into WB is only possible from
  // EXEC, where instr_q already holds the retiring instruction.
  always_comb begin
    ready_d = (state_d == ST_IDLE);
    busy_d  = (state_d != ST_IDLE);
    rd_en_d = (state_d == ST_READ);
    done_d  = (state_d == ST_WB);
    wr_en_d = (state_d == ST_WB) && !nop_s;
  end

  assign instr_ready = ready_q;
  assign busy        = busy_q;
  assign rf_rd_en    = rd_en_q;
  assign rf_wr_en    = wr_en_q;
  assign done        = done_q;
  assign rf_rd0_addr = ADDR_W'(src0_s);
  assign rf_rd1_addr = ADDR_W'(src1_s);
  assign rf_wr_addr  = ADDR_W'(dest_s);
  assign rf_wr_data  = result_q;
  assign alu_a       = alu_a_q;
  assign alu_b       = alu_b_q;
  assign alu_op      = opcode_s;

endmodule

// File: tb/tb_reg_file_seq.sv
// Bench for reg_file_seq: external register file and ALU are modelled here,
// a timeline model predicts every output each cycle, and directed vectors
// pin the model with hand-computed literals.
module tb_reg_file_seq;

  logic              clk = 1'b0;
  logic              rst = 1'b0;
  logic              instr_valid = 1'b0;
  logic              instr_ready;
  logic [8:0]        instr = 9'd0;
  logic              rf_rd_en;
  logic [1:0]        rf_rd0_addr, rf_rd1_addr;
  logic signed [8:0] rf_rd0_data = 9'sd0;
  logic signed [8:0] rf_rd1_data = 9'sd0;
  logic              rf_wr_en;
  logic [1:0]        rf_wr_addr;
  logic signed [8:0] rf_wr_data;
  logic signed [8:0] alu_a, alu_b;
  logic [2:0]        alu_op;
  logic signed [8:0] alu_result;
  logic              done;
  logic              busy;

  int checks = 0;
  int failures = 0;

  always #5 clk = ~clk;

  reg_file_seq dut (
    .clk(clk), .rst(rst), .instr_valid(instr_valid), .instr_ready(instr_ready),
    .instr(instr), .rf_rd_en(rf_rd_en), .rf_rd0_addr(rf_rd0_addr),
    .rf_rd1_addr(rf_rd1_addr), .rf_rd0_data(rf_rd0_data), .rf_rd1_data(rf_rd1_data),
    .rf_wr_en(rf_wr_en), .rf_wr_addr(rf_wr_addr), .rf_wr_data(rf_wr_data),
    .alu_a(alu_a), .alu_b(alu_b), .alu_op(alu_op), .alu_result(alu_result),
    .done(done), .busy(busy)
  );

  function automatic logic signed [8:0] alu_fn(input logic [2:0] op,
                                               input logic signed [8:0] a,
                                               input logic signed [8:0] b);
    case (op)
      3'b000:  return a + b;
      3'b001:  return a - b;
      default: return a ^ b;
    endcase
  endfunction

  task automatic chk(input string nm, input logic signed [31:0] act,
                     input logic signed [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s at %0t: got %0d expected %0d", nm, $time, act, exp);
    end
  endtask

  // External register file: registered read, write on the clock edge.
  logic              pre_en = 1'b0;
  logic [1:0]        pre_addr = 2'd0;
  logic signed [8:0] pre_data = 9'sd0;
  logic signed [8:0] rf_mem [4];

  always @(posedge clk) begin
    if (rf_rd_en) begin
      rf_rd0_data <= rf_mem[rf_rd0_addr];
      rf_rd1_data <= rf_mem[rf_rd1_addr];
    end
    if (pre_en) rf_mem[pre_addr] <= pre_data;
    else if (rf_wr_en) rf_mem[rf_wr_addr] <= rf_wr_data;
  end

  always_comb alu_result = alu_fn(alu_op, alu_a, alu_b);

  // Timeline model: ph counts cycles since the accepting edge (0 = idle).
  int                ph = 0;
  int                cyc = 0;
  int                acc_cnt = 0;
  int                acc_cyc [$];
  logic [2:0]        m_op = 3'd0;
  logic [1:0]        m_dst = 2'd0, m_s0 = 2'd0, m_s1 = 2'd0;
  logic signed [8:0] m_res = 9'sd0, cur_a = 9'sd0, cur_b = 9'sd0;
  logic signed [8:0] m_rf [4];

  always @(posedge clk) cyc <= cyc + 1;

  always @(posedge clk or negedge rst) begin
    if (!rst) begin
      ph <= 0;
      cur_a <= 9'sd0;
      cur_b <= 9'sd0;
      m_res <= 9'sd0;
    end else begin
      if (pre_en) m_rf[pre_addr] <= pre_data;
      if (ph == 0) begin
        if (instr_valid) begin
          ph <= 1;
          m_op <= instr[8:6]; m_dst <= instr[5:4];
          m_s0 <= instr[3:2]; m_s1 <= instr[1:0];
          acc_cnt <= acc_cnt + 1;
          acc_cyc.push_back(cyc);
        end
      end else if (ph == 1) begin
        ph <= 2;
      end else if (ph == 2) begin
        ph <= 3;
        cur_a <= m_rf[m_s0];
        cur_b <= m_rf[m_s1];
      end else if (ph == 3) begin
        ph <= 4;
        m_res <= alu_fn(m_op, cur_a, cur_b);
      end else begin
        ph <= 0;
        if (m_op != 3'b111) m_rf[m_dst] <= m_res;
      end
    end
  end

  // Per-cycle compare of every output against the model.
  always @(negedge clk) begin
    if (!rst) begin
      chk("rst_busy", busy, 0);
      chk("rst_rd_en", rf_rd_en, 0);
      chk("rst_wr_en", rf_wr_en, 0);
      chk("rst_done", done, 0);
      chk("rst_alu_a", alu_a, 0);
      chk("rst_alu_b", alu_b, 0);
      chk("rst_alu_op", alu_op, 0);
    end else begin
      chk("ready", instr_ready, (ph == 0));
      chk("busy", busy, (ph != 0));
      chk("busy_vs_ready", busy, !instr_ready);
      chk("rd_wr_overlap", (rf_rd_en && rf_wr_en), 0);
      chk("rd_en", rf_rd_en, (ph == 1));
      chk("wr_en", rf_wr_en, ((ph == 4) && (m_op != 3'b111)));
      chk("done", done, (ph == 4));
      chk("alu_a", alu_a, cur_a);
      chk("alu_b", alu_b, cur_b);
      if (ph == 1) begin
        chk("rd0_addr", rf_rd0_addr, m_s0);
        chk("rd1_addr", rf_rd1_addr, m_s1);
      end
      if (ph == 3) chk("alu_op", alu_op, m_op);
      if (ph == 4) begin
        chk("wr_addr", rf_wr_addr, m_dst);
        chk("wr_data", rf_wr_data, m_res);
      end
    end
  end

  task automatic preload(input logic [1:0] a, input logic signed [8:0] d);
    @(negedge clk);
    pre_en = 1'b1; pre_addr = a; pre_data = d;
    @(negedge clk);
    pre_en = 1'b0;
  endtask

  // Offer one instruction for one cycle; returns at the READ-cycle negedge.
  task automatic issue(input logic [8:0] w);
    @(negedge clk);
    instr_valid = 1'b1; instr = w;
    @(negedge clk);
    instr_valid = 1'b0;
  endtask

  // From the READ negedge, wait (bounded) for done; report negedges waited.
  task automatic wait_done(output int n);
    n = 0;
    while (done !== 1'b1 && n < 12) begin
      @(negedge clk);
      n++;
    end
  endtask

  int n;
  int acc0;

  initial begin
    repeat (3) @(negedge clk);
    #2 rst = 1'b1;
    @(negedge clk);
    chk("post_rst_ready", instr_ready, 1);
    chk("post_rst_busy", busy, 0);

    // a+b with r1=5, r2=-3 into r3.
    preload(2'd1, 9'sd5);
    preload(2'd2, -9'sd3);
    preload(2'd3, 9'sd0);
    preload(2'd0, 9'sd77);
    issue({3'b000, 2'd3, 2'd1, 2'd2});
    wait_done(n);
    chk("add_latency", n, 3);
    chk("add_wr_en", rf_wr_en, 1);
    chk("add_wr_addr", rf_wr_addr, 3);
    chk("add_wr_data", rf_wr_data, 2);
    chk("add_alu_a", alu_a, 5);
    chk("add_alu_b", alu_b, -3);
    @(negedge clk);
    chk("add_done_1cyc", done, 0);
    chk("add_ready_back", instr_ready, 1);
    chk("add_r3", rf_mem[3], 2);

    // NOP to r0: retires without writing.
    issue({3'b111, 2'd0, 2'd1, 2'd2});
    wait_done(n);
    chk("nop_latency", n, 3);
    chk("nop_wr_en", rf_wr_en, 0);
    @(negedge clk);
    chk("nop_r0", rf_mem[0], 77);

    // dest == src: r1=7 -> 14, then a follower reads the new r1.
    preload(2'd1, 9'sd7);
    issue({3'b000, 2'd1, 2'd1, 2'd1});
    wait_done(n);
    chk("self_wr_data", rf_wr_data, 14);
    issue({3'b000, 2'd2, 2'd1, 2'd0});
    wait_done(n);
    chk("fwd_alu_a", alu_a, 14);
    chk("fwd_wr_data", rf_wr_data, 91);

    // Wraparound at 9 bits: 200 + 100 = 300 -> -212.
    preload(2'd3, 9'sd200);
    preload(2'd2, 9'sd100);
    issue({3'b000, 2'd0, 2'd3, 2'd2});
    wait_done(n);
    chk("wrap_wr_data", rf_wr_data, -212);

    // Valid held 12 cycles starting in the EXEC of a running subtract.
    issue({3'b001, 2'd0, 2'd2, 2'd3});
    @(negedge clk);
    @(negedge clk);
    acc0 = acc_cnt;
    instr_valid = 1'b1;
    instr = {3'b000, 2'd1, 2'd0, 2'd0};
    repeat (12) @(negedge clk);
    instr_valid = 1'b0;
    chk("hold_accepts", acc_cnt - acc0, 2);
    if (acc_cyc.size() >= 2)
      chk("hold_gap", acc_cyc[acc_cyc.size()-1] - acc_cyc[acc_cyc.size()-2], 5);
    else
      chk("hold_gap_missing", acc_cyc.size(), 2);
    repeat (2) @(negedge clk);
    chk("hold_r1", rf_mem[1], -200);

    // Reset during EXEC: instruction dropped, r3 keeps 200.
    issue({3'b000, 2'd3, 2'd1, 2'd1});
    @(negedge clk);
    @(negedge clk);
    #2 rst = 1'b0;
    #1;
    chk("mid_rst_busy", busy, 0);
    chk("mid_rst_ready", instr_ready, 1);
    chk("mid_rst_alu_a", alu_a, 0);
    chk("mid_rst_alu_b", alu_b, 0);
    chk("mid_rst_wr_en", rf_wr_en, 0);
    @(negedge clk);
    #2 rst = 1'b1;
    repeat (6) @(negedge clk);
    chk("mid_rst_r3", rf_mem[3], 200);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

  // Global time limit so the run always ends.
  initial begin
    #20000;
    $display("FAIL timeout: got %0d expected %0d", 0, 1);
    failures++;
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/reg_file_seq.md
REG_FILE_SEQ -- requirements
Module: reg_file_seq

Interface
REQ-001 SHALL have parameter DATA_W, default 9, meaning register/ALU data width in bits.
REQ-002 SHALL have parameter ADDR_W, default 2, meaning register address width (4 registers).
REQ-003 SHALL have one clock and an asynchronous, active-low reset: clk input, rst input.
REQ-004 clk  in  1  single clock; all state updates on rising edge.
REQ-005 rst  in  1  asynchronous reset, active-low.
REQ-006 instr_valid  in  1  instruction offered.
REQ-007 instr_ready  out  1  sequencer can accept an instruction.
REQ-008 instr  in  9  [8:6] opcode, [5:4] dest, [3:2] src0, [1:0] src1.
REQ-009 rf_rd_en  out  1  register-file read strobe.
REQ-010 rf_rd0_addr, rf_rd1_addr  out  ADDR_W each  read addresses.
REQ-011 rf_rd0_data, rf_rd1_data  in  DATA_W signed each  registered read data, valid the cycle after rf_rd_en.
REQ-012 rf_wr_en  out  1  register-file write strobe.
REQ-013 rf_wr_addr  out  ADDR_W  write address.
REQ-014 rf_wr_data  out  DATA_W signed  write data.
REQ-015 alu_a, alu_b  out  DATA_W signed each  registered ALU operands.
REQ-016 alu_op  out  3  opcode to ALU.
REQ-017 alu_result  in  DATA_W signed  combinational ALU result.
REQ-018 done  out  1  one-cycle pulse on instruction retire.
REQ-019 busy  out  1  high in every state except IDLE.

Function
REQ-020 SHALL implement FSM states IDLE, READ, OPND, EXEC, WB.
REQ-021 IDLE: instr_ready=1; on instr_valid&&instr_ready, latch instr and go to READ; otherwise stay.
REQ-022 READ (1 cycle): rf_rd_en=1, rf_rd0_addr=src0, rf_rd1_addr=src1; go to OPND.
REQ-023 OPND (1 cycle): capture rf_rd0_data->alu_a, rf_rd1_data->alu_b at cycle end; go to EXEC.
REQ-024 EXEC (1 cycle): alu_op=latched opcode; capture alu_result into result register at cycle end; go to WB.
REQ-025 WB (1 cycle): rf_wr_en=1 unless opcode==3'b111 (NOP), rf_wr_addr=dest, rf_wr_data=result; done=1; go to IDLE.
REQ-026 Latency SHALL be fixed: handshake on edge N, rf_wr_en/done high in cycle N+4, instr_ready high again in cycle N+5.
REQ-027 instr_ready SHALL be 0 outside IDLE; instr_valid outside IDLE SHALL be ignored, no state change.
REQ-028 rf_rd_en and rf_wr_en SHALL never be high in the same cycle.
REQ-029 rf_rd_en SHALL be 0 outside READ; rf_wr_en and done SHALL be 0 outside WB.
REQ-030 NOP (3'b111) SHALL traverse all states and pulse done, with rf_wr_en=0.
REQ-031 dest equal to src0 or src1 SHALL be legal; read precedes write, so the old value is used.
REQ-032 Back-to-back instructions SHALL observe the previous write (the previous WB precedes the next READ by at least one cycle).
REQ-033 Data SHALL pass unmodified at DATA_W bits; no extension or saturation.
REQ-034 Addresses and opcode SHALL be held stable from READ through WB.

Reset
REQ-035 rst low SHALL immediately force IDLE regardless of clk, including mid-instruction; the in-flight instruction SHALL be dropped without a write.
REQ-036 During and after reset, all outputs SHALL be 0 except instr_ready (1 after release, in IDLE); latched instr, alu_a, alu_b and result SHALL be 0.

Structure
REQ-037 A shared package SHALL hold DATA_W/ADDR_W defaults, the state enum, opcode constants (OP_NOP=3'b111), and instr field bit positions.
REQ-038 A single sub-module, instr_decode (combinational field extraction and NOP flag), SHALL be used; the FSM and datapath registers SHALL be inline.

Verification
REQ-039 Preload r1=5, r2=-3; instr op=000, dest=3, src0=1, src1=2; ALU model returns a+b -> alu_a=5, alu_b=-3, rf_wr_addr=3, rf_wr_data=2 at N+4, done one cycle.
REQ-040 NOP op=111 dest=0 -> done at N+4, rf_wr_en never high, r0 unchanged.
REQ-041 instr_valid held high for 12 cycles -> exactly two accepts, 5 cycles apart; instr_ready low in cycles N+1..N+4.
REQ-042 rst low in EXEC -> next cycle state IDLE, rf_wr_en never asserts, busy=0, alu_a=alu_b=0.
REQ-043 op=000 dest=1, src0=1, src1=1 with r1=7 and ALU a+b -> writes 14; next instr reading r1 gets 14.
REQ-044 All cycles: assert rf_rd_en&&rf_wr_en never true and busy==!instr_ready.
